// File: rtl/pe_flit_injector.sv
// PE-side flit injector: turns packet descriptors and payload words into head/body/tail
// flits for a router PE port, claiming one VC per packet and honouring per-VC ON_OFF.
//
// state   | meaning
// IDLE    | waiting for a descriptor; illegal lengths are dropped with an err_o pulse
// ALLOC   | round-robin search for a VC whose ON_OFF is set
// HEAD    | VC owned; head flit goes out once that VC is ON
// PAYLOAD | one body/tail flit per accepted payload word while the VC is ON
module pe_flit_injector #(
    parameter int         flit_width     = 16,
    parameter int         MAX_Packet_NUM = 8,
    parameter logic [3:0] current_router = 4'b0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid_i,
    input  logic [3:0]            pkt_dest_i,
    input  logic [3:0]            pkt_len_i,
    output logic                  pkt_ready_o,
    input  logic                  data_valid_i,
    input  logic [11:0]           data_i,
    output logic                  data_ready_o,
    input  logic                  ON_OFF_0_i,
    input  logic                  ON_OFF_1_i,
    input  logic                  ON_OFF_2_i,
    input  logic                  ON_OFF_3_i,
    output logic [flit_width-1:0] FLIT_o,
    output logic                  VALID_O,
    output logic                  VC_0_RESERVED_O,
    output logic                  VC_1_RESERVED_O,
    output logic                  VC_2_RESERVED_O,
    output logic                  VC_3_RESERVED_O,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, ALLOC, HEAD, PAYLOAD} state_t;

    localparam logic [4:0] MAX_LEN = 5'(MAX_Packet_NUM);

    state_t                state, state_nxt;
    logic [3:0]            on_off_q;
    logic [3:0]            reserved_q;
    logic [1:0]            vc_q;
    logic [1:0]            rr_q;
    logic [3:0]            dest_q;
    logic [3:0]            len_q;
    logic [3:0]            rem_q;
    logic [flit_width-1:0] flit_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  err_q;

    logic                  len_ok;
    logic                  vc_on;
    logic                  alloc_found;
    logic [1:0]            alloc_vc;
    logic [1:0]            cand;
    logic                  head_fire;
    logic                  pay_fire;
    logic                  last_flit;

    assign len_ok    = (pkt_len_i != 4'd0) && ({1'b0, pkt_len_i} <= MAX_LEN);
    assign vc_on     = on_off_q[vc_q];
    assign last_flit = (rem_q == 4'd1);

    // Readies are gated by rst so they read 0 while reset is held, even though state is IDLE.
    assign pkt_ready_o  = (state == IDLE) && !rst;
    assign data_ready_o = (state == PAYLOAD) && data_valid_i && vc_on && !rst;
    assign head_fire    = (state == HEAD) && vc_on;
    assign pay_fire     = data_ready_o;

    // Descending scan so the candidate closest to the RR pointer wins.
    always_comb begin
        alloc_found = 1'b0;
        alloc_vc    = rr_q;
        cand        = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_q + 2'(i);
            if (on_off_q[cand]) begin
                alloc_found = 1'b1;
                alloc_vc    = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pkt_valid_i && len_ok)  state_nxt = ALLOC;
            ALLOC:   if (alloc_found)            state_nxt = HEAD;
            HEAD:    if (vc_on)                  state_nxt = PAYLOAD;
            PAYLOAD: if (pay_fire && last_flit)  state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            on_off_q   <= '0;
            reserved_q <= '0;
            vc_q       <= '0;
            rr_q       <= '0;
            dest_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            flit_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            on_off_q <= {ON_OFF_3_i, ON_OFF_2_i, ON_OFF_1_i, ON_OFF_0_i};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_valid_i) begin
                        dest_q <= pkt_dest_i;
                        len_q  <= pkt_len_i;
                        rem_q  <= pkt_len_i;
                        err_q  <= !len_ok;
                    end
                end
                ALLOC: begin
                    if (alloc_found) begin
                        vc_q       <= alloc_vc;
                        reserved_q <= 4'b0001 << alloc_vc;
                        busy_q     <= 1'b1;
                        rr_q       <= alloc_vc + 2'd1;
                    end
                end
                HEAD: begin
                    if (head_fire) begin
                        flit_q  <= {2'b01, vc_q, dest_q, current_router, len_q};
                        valid_q <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (pay_fire) begin
                        flit_q  <= {(last_flit ? 2'b10 : 2'b00), vc_q, data_i};
                        valid_q <= 1'b1;
                        rem_q   <= rem_q - 4'd1;
                        // VC is released on the same edge the tail is launched.
                        if (last_flit) begin
                            reserved_q <= '0;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign FLIT_o          = flit_q;
    assign VALID_O         = valid_q;
    assign VC_0_RESERVED_O = reserved_q[0];
    assign VC_1_RESERVED_O = reserved_q[1];
    assign VC_2_RESERVED_O = reserved_q[2];
    assign VC_3_RESERVED_O = reserved_q[3];
    assign busy_o          = busy_q;
    assign err_o           = err_q;

endmodule

// File: doc/pe_flit_injector.md
Name: pe_flit_injector

Overview:
- PE-side network interface transmitter that drives a router's PE input port.
- Accepts packet descriptors and payload words from the PE core and serialises them into head/body/tail flits on FLIT_o/VALID_O.
- Claims one of four virtual channels and holds its VC_x_RESERVED_O for the packet's duration.
- Obeys the router's per-VC ON_OFF backpressure; one packet in flight at a time.

Parameters:
flit_width, 16, flit width in bits (fixed format below requires 16)
MAX_Packet_NUM, 8, maximum payload flits per packet
current_router, 4'b0100, source address stamped into head flits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pkt_valid_i  in  1  packet descriptor valid
pkt_dest_i  in  4  destination router address
pkt_len_i  in  4  payload flit count
pkt_ready_o  out  1  descriptor accepted this cycle (valid&ready handshake)
data_valid_i  in  1  payload word valid
data_i  in  12  payload word
data_ready_o  out  1  payload word consumed this cycle
ON_OFF_0_i..ON_OFF_3_i  in  1 each  router VC k has buffer space (1 = may send)
FLIT_o  out  flit_width  flit to router PE_FLIT_i
VALID_O  out  1  flit valid, to router PE_VALID_i
VC_0_RESERVED_O..VC_3_RESERVED_O  out  1 each  VC k owned by the current packet
busy_o  out  1  packet in progress
err_o  out  1  one-cycle pulse: illegal length, packet dropped

Behaviour:
- Flit format: [15:14] type (01 head, 00 body, 10 tail); [13:12] VC id.
- Head flit: [11:8] dest, [7:4] current_router, [3:0] len.
- Body/tail flit: [11:0] payload.
- Reset values: FLIT_o=0, VALID_O=0, all VC_x_RESERVED_O=0, pkt_ready_o=0, data_ready_o=0, busy_o=0, err_o=0, RR pointer=0, state IDLE.
- All outputs are registered. data_ready_o and pkt_ready_o are combinational from state, registered ON_OFF status and data_valid_i, and are asserted only in the same cycle the corresponding flit is registered.
- FSM states: IDLE, ALLOC, HEAD, PAYLOAD.
- IDLE:
  - pkt_ready_o=1.
  - On pkt_valid_i, latch dest and len.
  - If len==0 or len>MAX_Packet_NUM: pulse err_o next cycle, stay IDLE, emit no flits.
  - Otherwise go to ALLOC.
- ALLOC:
  - Round-robin search starting at the RR pointer for a VC with ON_OFF_k_i=1.
  - If found: latch it as vc, set VC_vc_RESERVED_O=1, set RR pointer=vc+1 mod 4, go to HEAD.
  - If none is ON, stay in ALLOC indefinitely.
- HEAD: when ON_OFF_vc_i=1, register the head flit with VALID_O=1 for one cycle, then go to PAYLOAD. Otherwise hold with VALID_O=0.
- PAYLOAD:
  - Each cycle with data_valid_i=1 and ON_OFF_vc_i=1: data_ready_o=1, register a flit with VALID_O=1, decrement the remaining count.
  - The flit type is tail when remaining==1, else body.
  - Any other cycle: VALID_O=0 (bubble); FLIT_o holds its last value.
  - After the tail is registered: clear VC_vc_RESERVED_O in the same cycle VALID_O for the tail is high, go to IDLE.
- len==1 produces head then tail (no body). Minimum latency from descriptor to head VALID_O = 3 cycles (IDLE capture, ALLOC, HEAD).
- Exactly one VC_x_RESERVED_O is high while busy_o=1; none in IDLE.
- ON_OFF dropping mid-packet stalls emission only. VC ownership is retained; no flit is dropped or duplicated.
- A simultaneous ON_OFF drop and data_valid_i: no emission, data_ready_o=0.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned; the downstream router is cleared by the same reset.
- pkt_valid_i is ignored outside IDLE.

Test Plan:
- Single packet, all ON: dest=4'h9, len=2, payload 12'hABC, 12'h123 → FLITs 16'h4_9_4_2 (head, VC0: 0x4942), 0x0ABC, 0x8123 on consecutive cycles; VC_0_RESERVED_O high from ALLOC exit through tail cycle.
- RR allocation: three back-to-back len=1 packets, all ON → VC ids 0, 1, 2 in the head flits; each packet produces exactly two flits.
- Backpressure: ON_OFF_0_i low for 5 cycles during PAYLOAD of a len=4 packet → VALID_O=0 for those 5 cycles; total 5 flits still delivered in order, payloads intact.
- All VCs OFF at allocation → stays in ALLOC with no VALID_O and no reserved bit. Raise ON_OFF_2_i → VC2 chosen, head carries [13:12]=2.
- Illegal length: len=0, then len=9 → err_o pulses once for each, no VALID_O, pkt_ready_o stays 1.
- Reset mid-PAYLOAD after 2 of 4 payload flits → all outputs 0 next edge; a following packet starts with VC0 and a fresh head.
